// File: rtl/ram_seq_pkg.sv
// Shared types and pattern helper for the RAM fill/readback sequencer.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package ram_seq_pkg;

    // Controller phases: wait for start, fill, issue read, capture read data, finished
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Fill pattern for one location: (cnt + seed) mod 2^m.
    // Callers size-cast the result down to their data width.
    function automatic logic [31:0] pat(input logic [31:0] cnt,
                                        input logic [31:0] seed,
                                        input int unsigned m);
        logic [31:0] sum;
        sum = cnt + seed;
        if (m >= 32) begin
            return sum;
        end
        return sum & ((32'd1 << m) - 32'd1);
    endfunction

endpackage

// File: rtl/ram_addr_counter.sv
// N-bit RAM address counter with synchronous clear, increment enable and all-ones flag.
// Latency: count updates one cycle after clr_i/inc_i; tc_o is combinational from the count.
// Backpressure: none; the caller gates inc_i.
module ram_addr_counter #(
    parameter int N = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [N-1:0] cnt_o,
    output logic         tc_o
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Clear wins over increment; the increment wraps naturally at N bits
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + N'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = &cnt_q;

endmodule

// File: rtl/ram_seq_ctrl.sv
// Fills a single-port RAM with (addr + seed) and reads it back in order, one op per tick_i.
// Latency: strobes/address/data register one cycle after the tick; read data lands in dato_show_o one cycle after rden_o.
// Backpressure: none; ticks arriving in IDLE/WAIT/DONE are dropped. Readback check built only with RAM_SEQ_CTRL_VERIFY_EN.
module ram_seq_ctrl #(
    parameter int N = 3,
    parameter int M = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tick_i,
    input  logic         start_i,
    input  logic [M-1:0] seed_i,
    input  logic [M-1:0] dato_read_i,
    output logic [N-1:0] addr_o,
    output logic [M-1:0] dato_write_o,
    output logic         wren_o,
    output logic         rden_o,
    output logic [M-1:0] dato_show_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    import ram_seq_pkg::*;

    state_t       state_q, state_d;
    logic [M-1:0] seed_q,  seed_d;
    logic [N-1:0] addr_q,  addr_d;
    logic [M-1:0] dw_q,    dw_d;
    logic         wren_q,  wren_d;
    logic         rden_q,  rden_d;
    logic [M-1:0] show_q,  show_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
    logic         err_q,   err_d;
`endif

    logic [N-1:0] cnt;
    logic         cnt_tc;
    logic         cnt_clr;
    logic         cnt_inc;
    logic         start_ok;
    logic [M-1:0] pat_cur;

    // A start only counts when no pass is running
    assign start_ok = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign pat_cur  = M'(pat(32'(cnt), 32'(seed_q), M));

    ram_addr_counter #(.N(N)) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    // Counter control: restart on a new pass and after the last write; step after each write and each capture
    always_comb begin
        cnt_clr = start_ok || ((state_q == WRITE) && tick_i && cnt_tc);
        cnt_inc = ((state_q == WRITE) && tick_i && !cnt_tc) ||
                  ((state_q == WAIT) && !cnt_tc);
    end

    // State register and registered outputs; reset overrides start and tick
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            seed_q  <= '0;
            addr_q  <= '0;
            dw_q    <= '0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            show_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            addr_q  <= addr_d;
            dw_q    <= dw_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            show_q  <= show_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef RAM_SEQ_CTRL_VERIFY_EN
    // Sticky mismatch flag, cleared by reset or an accepted start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    // Next-state: fill all locations, then alternate read strobe / capture until the last address
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i)          state_d = WRITE;
            WRITE:      if (tick_i && cnt_tc) state_d = READ;
            READ:       if (tick_i)           state_d = WAIT;
            WAIT:       state_d = cnt_tc ? DONE : READ;
            default:    state_d = IDLE;
        endcase
    end

    // Output next values: strobes are single-cycle, address/data hold between operations
    always_comb begin
        seed_d = seed_q;
        addr_d = addr_q;
        dw_d   = dw_q;
        wren_d = 1'b0;
        rden_d = 1'b0;
        show_d = show_q;
        busy_d = (state_d == WRITE) || (state_d == READ) || (state_d == WAIT);
        done_d = (state_d == DONE);
`ifdef RAM_SEQ_CTRL_VERIFY_EN
        err_d  = err_q;
`endif
        if (start_ok) begin
            seed_d = seed_i;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
            err_d  = 1'b0;
`endif
        end
        if ((state_q == WRITE) && tick_i) begin
            wren_d = 1'b1;
            addr_d = cnt;
            dw_d   = pat_cur;
        end
        if ((state_q == READ) && tick_i) begin
            rden_d = 1'b1;
            addr_d = cnt;
        end
        if (state_q == WAIT) begin
            show_d = dato_read_i;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
            if (dato_read_i != pat_cur) begin
                err_d = 1'b1;
            end
`endif
        end
    end

    assign addr_o       = addr_q;
    assign dato_write_o = dw_q;
    assign wren_o       = wren_q;
    assign rden_o       = rden_q;
    assign dato_show_o  = show_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_seq_ctrl.sv
`timescale 1ns/1ps
module tb_ram_seq_ctrl;

    localparam int N = 3;
    localparam int M = 4;
    localparam int D = 1 << N;
`ifdef RAM_SEQ_CTRL_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_i;
    logic         tick_i;
    logic         start_i;
    logic [M-1:0] seed_i;
    logic [M-1:0] dato_read_i;
    logic [N-1:0] addr_o;
    logic [M-1:0] dato_write_o;
    logic         wren_o;
    logic         rden_o;
    logic [M-1:0] dato_show_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    // RAM model: synchronous write, asynchronous read, optional corruption of addr 3
    logic [M-1:0] mem [D];
    bit           corrupt;

    int           n_vec;
    int           n_err;
    logic [M-1:0] last_show;
    bit           err_model;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wren_o) mem[addr_o] <= dato_write_o;
    end

    assign dato_read_i = (corrupt && addr_o == N'(3)) ? '0 : mem[addr_o];

    ram_seq_ctrl #(.N(N), .M(M)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .dato_read_i  (dato_read_i),
        .addr_o       (addr_o),
        .dato_write_o (dato_write_o),
        .wren_o       (wren_o),
        .rden_o       (rden_o),
        .dato_show_o  (dato_show_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    // Expected fill value for location i: plain modular sum
    function automatic logic [M-1:0] exp_pat(input int i, input logic [M-1:0] s);
        int v;
        v = (i + int'(s)) % (1 << M);
        return v[M-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"}, 32'(addr_o), 0);
        chk({tag, "_wdat"}, 32'(dato_write_o), 0);
        chk({tag, "_wren"}, 32'(wren_o), 0);
        chk({tag, "_rden"}, 32'(rden_o), 0);
        chk({tag, "_show"}, 32'(dato_show_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_err"},  32'(err_o), 0);
    endtask

    // One pass. mode 0: tick always high, 1: tick every 4th cycle, 2: random tick and random start noise.
    // abort: assert reset when the controller sits in READ at address 4.
    task automatic run_pass(input logic [M-1:0] seed, input int mode, input bit corr, input bit abort);
        int cyc, wr_i, rd_i, cap;
        bit t, was_wait, exp_wr, exp_rd, capt;
        corrupt = corr;
        start_i = 1'b1;
        seed_i  = seed;
        tick_i  = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        seed_i  = ~seed;
        cyc = 1; wr_i = 0; rd_i = 0; cap = 0; was_wait = 0; err_model = 0;
        chk("start_busy", 32'(busy_o), 1);
        chk("start_done", 32'(done_o), 0);
        chk("start_err",  32'(err_o), 0);
        chk("start_wren", 32'(wren_o), 0);
        chk("start_rden", 32'(rden_o), 0);
        while (cap < D && cyc < 400) begin
            case (mode)
                0:       t = 1'b1;
                1:       t = (cyc % 4 == 0);
                default: t = 1'($urandom_range(0, 1));
            endcase
            tick_i  = t;
            start_i = (mode == 2) ? 1'($urandom_range(0, 1)) : (cyc == 3);
            exp_wr  = t && (wr_i < D);
            exp_rd  = t && (wr_i == D) && !was_wait && (rd_i < D);
            @(posedge clk); #1;
            cyc++;
            capt = was_wait;
            chk("wren", 32'(wren_o), 32'(exp_wr));
            chk("rden", 32'(rden_o), 32'(exp_rd));
            if (exp_wr) begin
                chk("wr_addr", 32'(addr_o), 32'(wr_i));
                chk("wr_data", 32'(dato_write_o), 32'(exp_pat(wr_i, seed)));
                wr_i++;
            end
            if (exp_rd) begin
                chk("rd_addr", 32'(addr_o), 32'(rd_i));
                rd_i++;
            end
            if (was_wait) begin
                last_show = (corr && cap == 3) ? '0 : exp_pat(cap, seed);
                if (VERIFY && corr && cap == 3) err_model = 1'b1;
                cap++;
            end
            chk("show", 32'(dato_show_o), 32'(last_show));
            chk("err",  32'(err_o), 32'(err_model));
            chk("done", 32'(done_o), 32'(cap == D));
            chk("busy", 32'(busy_o), 32'(cap != D));
            was_wait = exp_rd;
            if (abort && capt && cap == 4) begin
                tick_i  = 1'b1;
                start_i = 1'b1;
                rst_i   = 1'b1;
                @(posedge clk); #1;
                chk_reset_vals("abort");
                rst_i     = 1'b0;
                start_i   = 1'b0;
                last_show = '0;
                err_model = 1'b0;
                corrupt   = 1'b0;
                return;
            end
        end
        start_i = 1'b0;
        chk("pass_complete", 32'(cap), 32'(D));
        if (mode == 0) chk("pass_len", 32'(cyc), 32'(1 + 3 * D));
        // DONE holds and ignores ticks
        repeat (3) begin
            tick_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("hold_done", 32'(done_o), 1);
            chk("hold_busy", 32'(busy_o), 0);
            chk("hold_wren", 32'(wren_o), 0);
            chk("hold_rden", 32'(rden_o), 0);
            chk("hold_err",  32'(err_o), 32'(err_model));
            chk("hold_show", 32'(dato_show_o), 32'(last_show));
        end
        corrupt = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0;
        rst_i = 1'b1; tick_i = 1'b0; start_i = 1'b0; seed_i = '0;
        corrupt = 1'b0; last_show = '0; err_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_i  = 1'b0;
        tick_i = 1'b1;
        // IDLE ignores ticks
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_wren", 32'(wren_o), 0);
            chk("idle_rden", 32'(rden_o), 0);
            chk("idle_busy", 32'(busy_o), 0);
            chk("idle_done", 32'(done_o), 0);
        end
        run_pass(4'h5, 0, 1'b0, 1'b0);
        run_pass(4'hE, 0, 1'b0, 1'b0);
        run_pass(4'($urandom_range(0, 15)), 1, 1'b0, 1'b0);
        run_pass(4'h9, 0, 1'b1, 1'b0);
        run_pass(4'h0, 0, 1'b0, 1'b0);
        run_pass(4'($urandom_range(0, 15)), 2, 1'b0, 1'b1);
        run_pass(4'($urandom_range(0, 15)), 2, 1'b0, 1'b0);
        repeat (3) run_pass(4'($urandom_range(0, 15)), 2, 1'($urandom_range(0, 1)), 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
